// File: rtl/led_scan_reader.sv
// led_scan_reader: sweeps SYS_output_sel over all debug selections, snapshots
// SYS_leds for each one, then sends the snapshot as one UART 8N1 frame on tx.
// The frame is the header byte A5, then each 32-bit word least-significant
// byte first.
// Optional macro LED_SCAN_CHECKSUM_EN appends an XOR checksum byte that covers
// every preceding byte, the header included.
module led_scan_reader #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_SEL       = 8,
    parameter int LED_W         = 27
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             start,
    input  logic [LED_W-1:0] SYS_leds,
    output logic [2:0]       SYS_output_sel,
    output logic             tx,
    output logic             busy,
    output logic             done
);

`ifdef LED_SCAN_CHECKSUM_EN
    localparam int NUM_BYTES = 2 + 4 * NUM_SEL;
`else
    localparam int NUM_BYTES = 1 + 4 * NUM_SEL;
`endif
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_XMIT, S_FIN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_sel;
    logic [SET_W-1:0]   r_settle;
    logic [BAUD_W-1:0]  r_baud;
    logic [3:0]         r_bit;
    logic [5:0]         r_byte;
    logic [31:0]        r_buf [NUM_SEL];
`ifdef LED_SCAN_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic               w_cap;
    logic               w_sel_last;
    logic               w_bit_end;
    logic               w_byte_end;
    logic               w_frame_end;
    logic [2:0]         w_word;
    logic [1:0]         w_lane;
    logic [31:0]        w_word_val;
    logic [7:0]         w_cur_byte;
    logic [2:0]         w_bidx;

    assign w_cap       = (r_state == S_SCAN) && (r_settle == SET_W'(SETTLE_CYCLES - 1));
    assign w_sel_last  = (r_sel == 3'(NUM_SEL - 1));
    assign w_bit_end   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_byte_end  = w_bit_end && (r_bit == 4'd9);
    assign w_frame_end = w_byte_end && (r_byte == 6'(NUM_BYTES - 1));

    // Data byte k (k >= 1) is lane (k-1)%4 of word (k-1)/4
    assign w_word     = 3'((r_byte - 6'd1) >> 2);
    assign w_lane     = 2'(r_byte - 6'd1);
    assign w_word_val = r_buf[w_word];
    assign w_bidx     = 3'(r_bit - 4'd1);

    // Select the byte currently on the wire
    always_comb begin
        w_cur_byte = 8'hA5;
        if (r_byte != 6'd0) begin
            case (w_lane)
                2'd0:    w_cur_byte = w_word_val[7:0];
                2'd1:    w_cur_byte = w_word_val[15:8];
                2'd2:    w_cur_byte = w_word_val[23:16];
                default: w_cur_byte = w_word_val[31:24];
            endcase
`ifdef LED_SCAN_CHECKSUM_EN
            if (r_byte == 6'(NUM_BYTES - 1))
                w_cur_byte = r_csum;
`endif
        end
    end

    // State register
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and output decode; tx comes straight from registered state so
    // a reset drives it high right after the reset edge
    always_comb begin
        w_next         = r_state;
        tx             = 1'b1;
        busy           = 1'b0;
        done           = 1'b0;
        SYS_output_sel = '0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_SCAN;
            end
            S_SCAN: begin
                busy           = 1'b1;
                SYS_output_sel = r_sel;
                if (w_cap && w_sel_last)
                    w_next = S_XMIT;
            end
            S_XMIT: begin
                busy = 1'b1;
                case (r_bit)
                    4'd0:    tx = 1'b0;
                    4'd9:    tx = 1'b1;
                    default: tx = w_cur_byte[w_bidx];
                endcase
                if (w_frame_end)
                    w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sweep, baud, bit and byte counters; cleared whenever not scanning or sending
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            r_sel    <= '0;
            r_settle <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
`ifdef LED_SCAN_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (w_cap) begin
                        r_settle <= '0;
                        r_sel    <= w_sel_last ? 3'd0 : r_sel + 3'd1;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_XMIT: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 4'd9) begin
                            r_bit  <= '0;
                            r_byte <= r_byte + 6'd1;
`ifdef LED_SCAN_CHECKSUM_EN
                            r_csum <= r_csum ^ w_cur_byte;
`endif
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_sel    <= '0;
                    r_settle <= '0;
                    r_baud   <= '0;
                    r_bit    <= '0;
                    r_byte   <= '0;
`ifdef LED_SCAN_CHECKSUM_EN
                    r_csum   <= '0;
`endif
                end
            endcase
        end
    end

    // Snapshot capture: the bus is sampled only on the last settle cycle of each selection
    always_ff @(posedge SYS_clk) begin
        if (w_cap)
            r_buf[r_sel] <= 32'(SYS_leds);
    end

endmodule

// File: tb/tb_led_scan_reader.sv
// Directed bench for led_scan_reader: reset, constant bus, per-select bus,
// start during transmit, reset mid-frame, and the checksum byte when
// LED_SCAN_CHECKSUM_EN is defined.
module tb_led_scan_reader;

    localparam int CPB = 4;
    localparam int SET = 2;
    localparam int NS  = 8;
    localparam int LW  = 27;
`ifdef LED_SCAN_CHECKSUM_EN
    localparam int NB = 34;
`else
    localparam int NB = 33;
`endif
    localparam int LAT = NS * SET + NB * 10 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] leds;
    logic [2:0]    sel;
    logic          tx, busy, done;

    logic          mode = 1'b0;
    logic [LW-1:0] leds_const = '0;
    logic [31:0]   model_w [8];
    logic [7:0]    got [64];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc = 0;

    // System side of the select interface
    always_comb leds = mode ? ((sel == 3'd7) ? 27'h7FFFFFF : LW'(sel)) : leds_const;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which done was high
    always @(posedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    led_scan_reader #(
        .CLKS_PER_BIT (CPB),
        .SETTLE_CYCLES(SET),
        .NUM_SEL      (NS),
        .LED_W        (LW)
    ) dut (
        .SYS_clk       (clk),
        .SYS_reset     (rst_n),
        .start         (start),
        .SYS_leds      (leds),
        .SYS_output_sel(sel),
        .tx            (tx),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
    endtask

    task automatic rx_byte(output logic [7:0] b);
        int w = 0;
        while (tx !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("rx_start", 32'(tx), 32'd0);
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("rx_stop", 32'(tx), 32'd1);
    endtask

    task automatic rx_frame(input int n, input int poke);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            rx_byte(b);
            got[k] = b;
            if (k == poke) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("poke_busy", 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] x = 8'h00;
        logic [7:0] e;
        logic [31:0] wv;
        for (int k = 0; k < NB; k++) begin
            if (k == 0) begin
                e = 8'hA5;
            end else if (k > 4 * NS) begin
                e = x;
            end else begin
                wv = model_w[(k - 1) / 4] >> (8 * ((k - 1) % 4));
                e  = wv[7:0];
            end
            chk(tag, 32'(got[k]), 32'(e));
            x = x ^ e;
        end
    endtask

    task automatic wait_done(input int prev);
        int w = 0;
        while (done_cnt == prev && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", done_cnt, prev + 1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int prev;
        int lows;

        // 1: reset held with start high
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sel", 32'(sel), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx", 32'(tx), 32'd1);

        // 2: constant bus
        mode = 1'b0;
        leds_const = 27'h1234567;
        for (int s = 0; s < 8; s++) model_w[s] = 32'h01234567;
        prev = done_cnt;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            chk("scan_sel", 32'(sel), i / 2);
            chk("scan_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rx_frame(NB, -1);
        check_frame("c2_byte");
        chk("c2_hdr", 32'(got[0]), 32'hA5);
        chk("c2_b1", 32'(got[1]), 32'h67);
        chk("c2_b4", 32'(got[4]), 32'h01);
        chk("c2_b32", 32'(got[32]), 32'h01);
        wait_done(prev);
        chk("c2_lat", done_cyc - acc, LAT);

        // 3: per-select bus
        mode = 1'b1;
        for (int s = 0; s < 8; s++) model_w[s] = (s == 7) ? 32'h07FFFFFF : s;
        prev = done_cnt;
        pulse_start();
        rx_frame(NB, -1);
        check_frame("c3_byte");
        for (int k = 1; k <= 4; k++) chk("c3_w0", 32'(got[k]), 32'h00);
        chk("c3_w3b0", 32'(got[13]), 32'h03);
        chk("c3_w3b1", 32'(got[14]), 32'h00);
        chk("c3_w3b3", 32'(got[16]), 32'h00);
        chk("c3_w7b0", 32'(got[29]), 32'hFF);
        chk("c3_w7b1", 32'(got[30]), 32'hFF);
        chk("c3_w7b2", 32'(got[31]), 32'hFF);
        chk("c3_w7b3", 32'(got[32]), 32'h07);
        wait_done(prev);
        chk("c3_lat", done_cyc - acc, LAT);

        // 4: start during transmit is ignored
        mode = 1'b0;
        leds_const = 27'h0ABCDEF;
        for (int s = 0; s < 8; s++) model_w[s] = 32'h00ABCDEF;
        prev = done_cnt;
        pulse_start();
        rx_frame(NB, 5);
        check_frame("c4_byte");
        wait_done(prev);
        chk("c4_lat", done_cyc - acc, LAT);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("c4_no_extra", lows, 0);
        chk("c4_one_done", done_cnt, prev + 1);
        chk("c4_idle", 32'(busy), 32'd0);

        // 5: reset inside byte 10 data bits
        prev = done_cnt;
        pulse_start();
        rx_frame(10, -1);
        lows = 0;
        while (tx !== 1'b0 && lows < 200) begin
            @(negedge clk);
            lows++;
        end
        chk("c5_b10_start", 32'(tx), 32'd0);
        repeat (2 + CPB * 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("c5_rst_tx", 32'(tx), 32'd1);
        chk("c5_rst_busy", 32'(busy), 32'd0);
        chk("c5_rst_sel", 32'(sel), 32'd0);
        rst_n = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("c5_no_resume", lows, 0);
        chk("c5_no_done", done_cnt, prev);
        pulse_start();
        rx_frame(NB, -1);
        chk("c5_hdr", 32'(got[0]), 32'hA5);
        check_frame("c5_byte");
        wait_done(prev);
        chk("c5_lat", done_cyc - acc, LAT);

`ifdef LED_SCAN_CHECKSUM_EN
        // 6: checksum byte with an all-zero bus
        leds_const = '0;
        for (int s = 0; s < 8; s++) model_w[s] = 32'h0;
        prev = done_cnt;
        pulse_start();
        rx_frame(NB, -1);
        check_frame("c6_byte");
        chk("c6_csum", 32'(got[33]), 32'hA5);
        wait_done(prev);
        chk("c6_lat", done_cyc - acc, 16 + 1320 + 40);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_scan_reader.md
Name: led_scan_reader

Overview:
- Debug readout block: the reading end of the system's LED output-select interface.
- Drives SYS_output_sel through every selection, waits for settling, and captures SYS_leds for each selection into an internal snapshot buffer.
- Then serialises the snapshot as one UART 8N1 frame on tx.
- Lets a host dump all internal debug views in one transaction, without bench pokes or manual switch changes.

Parameters:
- CLKS_PER_BIT, 868, SYS_clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- SETTLE_CYCLES, 4, cycles each selection is held before capture; must be >= 1.
- NUM_SEL, 8, number of selections swept (0..NUM_SEL-1); must be <= 8.
- LED_W, 27, width of SYS_leds; must be <= 32.

Ports:
- SYS_clk  input  1  system clock; all logic is on the rising edge.
- SYS_reset  input  1  reset, synchronous, active-low (0 = reset).
- start  input  1  request one scan+dump; sampled only in IDLE.
- SYS_leds  input  LED_W  selected debug value returned by the system.
- SYS_output_sel  output  3  selection driven into the system.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high while a scan or transmit is in progress.
- done  output  1  one-cycle pulse when the frame's last stop bit completes.

Behaviour:
- Reset (SYS_reset=0 at a rising edge):
  - tx=1, busy=0, done=0, SYS_output_sel=0.
  - FSM goes to IDLE; all counters clear.
  - Buffer contents are don't-care.
  - Reset mid-operation aborts immediately. tx returns high on the next edge, even mid-bit, and no partial frame resumes.
- FSM states: IDLE -> SCAN -> XMIT -> FIN -> IDLE.
- IDLE:
  - tx=1, SYS_output_sel=0.
  - start=1 at an edge enters SCAN with sel=0, busy=1, settle counter=0.
- SCAN:
  - SYS_output_sel=sel; the settle counter increments each cycle.
  - At the edge where the counter reaches SETTLE_CYCLES-1, SYS_leds is written to buf[sel], zero-extended to 32 bits.
  - On that same edge, if sel<NUM_SEL-1: sel increments and the counter clears. Otherwise go to XMIT.
  - SCAN therefore lasts exactly NUM_SEL*SETTLE_CYCLES cycles.
  - The bus is sampled only on the capture edge.
- XMIT byte order:
  - Header byte 8'hA5.
  - Then, for sel 0..NUM_SEL-1, four bytes of buf[sel], least-significant byte first.
  - With defaults: B = 1 + 4*NUM_SEL = 33 bytes.
- XMIT bit format:
  - Each byte is sent as start bit (0), data bits LSB first, stop bit (1).
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - Bytes are back-to-back with no idle gap; the first start bit begins on the edge entering XMIT.
- FIN:
  - One cycle: done=1, busy=0, tx=1; then IDLE.
  - done asserts NUM_SEL*SETTLE_CYCLES + B*10*CLKS_PER_BIT cycles after the edge that accepted start.
- start while busy=1 is ignored and not queued. start held high through FIN starts a new scan from IDLE on the following cycle.
- SYS_leds changing mid-SCAN affects only the not-yet-captured selections. Snapshot data is frozen during XMIT.
- Bit counter and baud counter wrap locally per bit and per byte; there is no wrap across bytes.

Optional Feature:
- Macro: LED_SCAN_CHECKSUM_EN
- Defined:
  - One extra byte follows the last data byte: XOR of all preceding bytes, header included.
  - B = 2 + 4*NUM_SEL; done timing is extended accordingly.
- Undefined: no checksum byte; B = 1 + 4*NUM_SEL.

Test Plan:
1. Reset: hold SYS_reset=0 for 2 cycles with start=1 -> tx=1, busy=0, done=0, SYS_output_sel=0 throughout; no frame starts.
2. Constant bus (CLKS_PER_BIT=4, SETTLE_CYCLES=2, SYS_leds=27'h1234567, start pulse):
   - SYS_output_sel steps 0..7, holding each for 2 cycles.
   - tx bytes are A5, then {67 45 23 01} repeated 8 times.
   - done pulses exactly 16+1320=1336 cycles after start is accepted.
3. Per-select model (bench returns SYS_leds = sel==7 ? 27'h7FFFFFF : sel):
   - Word0 = 00 00 00 00 and word3 = 03 00 00 00.
   - Word7 = FF FF FF 07 (upper 5 bits zero).
4. start pulse during XMIT -> ignored; exactly 33 bytes are sent, one done pulse.
5. SYS_reset=0 in the middle of byte 10's data bits -> tx=1 on the next edge, busy=0; a fresh start yields a complete frame beginning with A5.
6. With LED_SCAN_CHECKSUM_EN and SYS_leds=0:
   - 34 bytes are sent; the last byte is A5 (XOR of A5 and thirty-two 00 bytes).
   - done arrives 40 cycles later than in case 2's timing.
